// File: rtl/neuron_bank_scheduler_if.sv
// rtl/neuron_bank_scheduler_if.sv - CPU register bus between host and neuron bank scheduler
interface neuron_bank_scheduler_if #(
    parameter int ADDR_WIDTH = 10
);
    logic [ADDR_WIDTH-1:0] address;
    logic                  read_enable;
    logic                  write_enable;
    logic [31:0]           write_data;
    logic [31:0]           read_data;
    logic                  ready;

    modport master (
        output address, read_enable, write_enable, write_data,
        input  read_data, ready
    );

    modport slave (
        input  address, read_enable, write_enable, write_data,
        output read_data, ready
    );
endinterface

// File: rtl/neuron_bank_scheduler.sv
// rtl/neuron_bank_scheduler.sv - sequences a timestep across neuron cores and queues spike events
module neuron_bank_scheduler #(
    parameter int NUM_NEURONS = 8,
    parameter int ADDR_WIDTH  = 10,
    parameter int FIFO_DEPTH  = 16,
    parameter int TIMEOUT     = 255
) (
    input  logic                      clk,
    input  logic                      rst,
    neuron_bank_scheduler_if.slave    bus,
    output logic [32*NUM_NEURONS-1:0] core_input,
    output logic [NUM_NEURONS-1:0]    core_start,
    output logic [NUM_NEURONS-1:0]    core_resolve,
    input  logic [NUM_NEURONS-1:0]    core_busy,
    input  logic [NUM_NEURONS-1:0]    core_spike,
    output logic                      step_done,
    output logic                      irq
);
    localparam int IDXW = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1;
    localparam int PTRW = $clog2(FIFO_DEPTH);
    localparam int CNTW = PTRW + 1;
    localparam int TOW  = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_ARM, S_WAIT, S_CAPTURE, S_NEXT
    } state_t;

    state_t                   r_state;
    logic [IDXW-1:0]          r_idx;
    logic [TOW-1:0]           r_wait_cnt;
    logic                     r_timed_out;
    logic [31:0]              r_step_count;
    logic                     r_irq_en;
    logic                     r_auto_clear;
    logic                     r_overflow;
    logic                     r_timeout;
    logic [NUM_NEURONS-1:0]   r_core_start;
    logic [NUM_NEURONS-1:0]   r_core_resolve;
    logic                     r_step_done;
    logic                     r_ready;
    logic [31:0]              r_read_data;
    logic [31:0]              r_input [NUM_NEURONS];
    logic [30:0]              r_mem [FIFO_DEPTH];
    logic [PTRW-1:0]          r_wr_ptr;
    logic [PTRW-1:0]          r_rd_ptr;
    logic [CNTW-1:0]          r_count;

    logic [31:0]              w_addr32;
    logic [IDXW-1:0]          w_in_idx;
    logic                     w_is_input;
    logic                     w_wr_input;
    logic                     w_wr_ctrl;
    logic                     w_wr_status;
    logic                     w_busy;
    logic                     w_empty;
    logic                     w_full;
    logic                     w_pop;
    logic                     w_push;
    logic                     w_push_ok;
    logic [31:0]              w_entry;
    logic [NUM_NEURONS-1:0]   w_cur_onehot;
    logic [31:0]              w_rd_mux;

    assign w_addr32     = 32'(bus.address);
    assign w_in_idx     = IDXW'(w_addr32);
    assign w_is_input   = w_addr32 < 32'(NUM_NEURONS);
    assign w_wr_input   = bus.write_enable && w_is_input;
    assign w_wr_ctrl    = bus.write_enable && (w_addr32 == 32'h200);
    assign w_wr_status  = bus.write_enable && (w_addr32 == 32'h201);
    assign w_busy       = (r_state != S_IDLE);
    assign w_empty      = (r_count == '0);
    assign w_full       = (r_count == CNTW'(FIFO_DEPTH));
    assign w_pop        = bus.read_enable && (w_addr32 == 32'h203) && !w_empty;
    assign w_push       = (r_state == S_CAPTURE) && core_spike[r_idx] && !r_timed_out;
    // A pop in the same cycle frees the slot, so a push onto a full FIFO still lands.
    assign w_push_ok    = w_push && (!w_full || w_pop);
    assign w_entry      = {8'h00, r_step_count[15:0], 8'(r_idx)};
    assign w_cur_onehot = NUM_NEURONS'(1) << r_idx;

    assign bus.read_data = r_read_data;
    assign bus.ready     = r_ready;
    assign core_start    = r_core_start;
    assign core_resolve  = r_core_resolve;
    assign step_done     = r_step_done;
    assign irq           = r_irq_en && !w_empty;

    for (genvar n = 0; n < NUM_NEURONS; n++) begin : g_core_input
        assign core_input[32*n +: 32] = r_input[n];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= S_IDLE;
            r_idx          <= '0;
            r_wait_cnt     <= '0;
            r_timed_out    <= 1'b0;
            r_step_count   <= '0;
            r_irq_en       <= 1'b0;
            r_auto_clear   <= 1'b0;
            r_overflow     <= 1'b0;
            r_timeout      <= 1'b0;
            r_core_start   <= '0;
            r_core_resolve <= '0;
            r_step_done    <= 1'b0;
            r_ready        <= 1'b0;
            for (int n = 0; n < NUM_NEURONS; n++) r_input[n] <= '0;
        end else begin
            r_ready        <= 1'b1;
            r_core_start   <= '0;
            r_core_resolve <= '0;
            r_step_done    <= 1'b0;
            if (w_wr_input && !w_busy) r_input[w_in_idx] <= bus.write_data;
            if (w_wr_ctrl) begin
                r_irq_en     <= bus.write_data[1];
                r_auto_clear <= bus.write_data[2];
            end
            if (w_wr_status && bus.write_data[3]) r_overflow <= 1'b0;
            if (w_wr_status && bus.write_data[4]) r_timeout  <= 1'b0;
            if (w_push && w_full && !w_pop) r_overflow <= 1'b1;
            case (r_state)
                S_IDLE: begin
                    if (w_wr_ctrl && bus.write_data[0]) begin
                        r_idx        <= '0;
                        r_core_start <= NUM_NEURONS'(1);
                        r_state      <= S_START;
                    end
                end
                S_START: r_state <= S_ARM;
                S_ARM: begin
                    r_wait_cnt  <= '0;
                    r_timed_out <= 1'b0;
                    r_state     <= S_WAIT;
                end
                S_WAIT: begin
                    if (!core_busy[r_idx]) begin
                        r_state <= S_CAPTURE;
                    end else if (r_wait_cnt == TOW'(TIMEOUT - 1)) begin
                        r_timed_out <= 1'b1;
                        r_timeout   <= 1'b1;
                        r_state     <= S_CAPTURE;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 1'b1;
                    end
                end
                S_CAPTURE: begin
                    if (core_spike[r_idx] && !r_timed_out) r_core_resolve <= w_cur_onehot;
                    r_state <= S_NEXT;
                end
                S_NEXT: begin
                    if (r_idx == IDXW'(NUM_NEURONS - 1)) begin
                        r_step_count <= r_step_count + 32'd1;
                        r_step_done  <= 1'b1;
                        if (r_auto_clear) begin
                            for (int n = 0; n < NUM_NEURONS; n++) r_input[n] <= '0;
                        end
                        r_state <= S_IDLE;
                    end else begin
                        r_idx        <= r_idx + 1'b1;
                        r_core_start <= w_cur_onehot << 1;
                        r_state      <= S_START;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        w_rd_mux = '0;
        if (w_is_input) begin
            w_rd_mux = r_input[w_in_idx];
        end else begin
            case (w_addr32)
                32'h200: w_rd_mux = {29'b0, r_auto_clear, r_irq_en, 1'b0};
                32'h201: w_rd_mux = {27'b0, r_timeout, r_overflow, w_full, w_empty, w_busy};
                32'h202: w_rd_mux = r_step_count;
                32'h203: w_rd_mux = w_empty ? 32'h0 : {1'b1, r_mem[r_rd_ptr]};
                32'h204: w_rd_mux = 32'(r_count);
                default: w_rd_mux = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push_ok) r_mem[r_wr_ptr] <= w_entry[30:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_read_data <= '0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)     r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count <= r_count + CNTW'(w_push_ok) - CNTW'(w_pop);
            if (bus.read_enable) r_read_data <= w_rd_mux;
        end
    end
endmodule

// File: tb/tb_neuron_bank_scheduler.sv
// tb/tb_neuron_bank_scheduler.sv - directed self-checking bench for neuron_bank_scheduler
module tb_neuron_bank_scheduler;
    localparam int N = 8;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [32*N-1:0] core_input;
    logic [N-1:0]   core_start;
    logic [N-1:0]   core_resolve;
    logic [N-1:0]   core_busy = '0;
    logic [N-1:0]   core_spike = '0;
    logic           step_done;
    logic           irq;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int done_cnt = 0;
    int start_q[$];
    int start_t[$];
    int resolve_cnt[N];

    neuron_bank_scheduler_if #(.ADDR_WIDTH(10)) bus();

    neuron_bank_scheduler #(
        .NUM_NEURONS(N), .ADDR_WIDTH(10), .FIFO_DEPTH(16), .TIMEOUT(255)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus),
        .core_input(core_input), .core_start(core_start), .core_resolve(core_resolve),
        .core_busy(core_busy), .core_spike(core_spike),
        .step_done(step_done), .irq(irq)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        cyc++;
        for (int i = 0; i < N; i++) begin
            if (core_start[i] === 1'b1) begin
                start_q.push_back(i);
                start_t.push_back(cyc);
            end
            if (core_resolve[i] === 1'b1) resolve_cnt[i]++;
        end
        if (step_done === 1'b1) done_cnt++;
    end

    task automatic do_reset();
        rst = 1'b1;
        bus.read_enable = 1'b0;
        bus.write_enable = 1'b0;
        bus.address = '0;
        bus.write_data = '0;
        core_busy = '0;
        core_spike = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic cpu_write(input logic [9:0] a, input logic [31:0] d);
        bus.address = a;
        bus.write_data = d;
        bus.write_enable = 1'b1;
        @(posedge clk);
        #1 bus.write_enable = 1'b0;
    endtask

    task automatic cpu_read(input logic [9:0] a, output logic [31:0] d);
        bus.address = a;
        bus.read_enable = 1'b1;
        @(posedge clk);
        #1 bus.read_enable = 1'b0;
        d = bus.read_data;
    endtask

    task automatic wait_done(input int base, input int limit, output bit ok);
        int n = 0;
        while (done_cnt == base && n < limit) begin
            @(posedge clk);
            #1;
            n++;
        end
        ok = (done_cnt != base);
    endtask

    task automatic test_reset();
        logic [31:0] rd;
        rst = 1'b1;
        bus.read_enable = 1'b0;
        bus.write_enable = 1'b0;
        bus.address = '0;
        bus.write_data = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (bus.ready !== 1'b0) begin errors++; $display("FAIL rst_ready got=%b exp=0", bus.ready); end
        checks++; if (bus.read_data !== 32'h0) begin errors++; $display("FAIL rst_read_data got=%h exp=0", bus.read_data); end
        checks++; if (core_start !== '0 || core_resolve !== '0 || step_done !== 1'b0 || irq !== 1'b0) begin
            errors++; $display("FAIL rst_outputs got start=%h resolve=%h done=%b irq=%b exp all 0", core_start, core_resolve, step_done, irq);
        end
        checks++; if (core_input !== '0) begin errors++; $display("FAIL rst_core_input got=%h exp=0", core_input); end
        rst = 1'b0;
        @(posedge clk);
        #1;
        checks++; if (bus.ready !== 1'b1) begin errors++; $display("FAIL ready_after_rst got=%b exp=1", bus.ready); end
        cpu_read(10'h201, rd);
        checks++; if (rd !== 32'h2) begin errors++; $display("FAIL rst_status got=%h exp=%h", rd, 32'h2); end
        cpu_read(10'h202, rd);
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL rst_step_count got=%h exp=0", rd); end
    endtask

    task automatic test_basic_step();
        logic [31:0] rd;
        bit ok;
        int base_s;
        int base_d;
        do_reset();
        cpu_write(10'h003, 32'h41200000);
        cpu_read(10'h003, rd);
        checks++; if (rd !== 32'h41200000) begin errors++; $display("FAIL input3_rb got=%h exp=41200000", rd); end
        checks++; if (core_input[127:96] !== 32'h41200000) begin errors++; $display("FAIL core_input3 got=%h exp=41200000", core_input[127:96]); end
        cpu_write(10'h300, 32'hDEADBEEF);
        cpu_read(10'h300, rd);
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL unmapped_read got=%h exp=0", rd); end
        base_s = start_q.size();
        base_d = done_cnt;
        cpu_write(10'h200, 32'h1);
        cpu_write(10'h200, 32'h1);
        wait_done(base_d, 100, ok);
        checks++; if (!ok) begin errors++; $display("FAIL basic_step_done got=timeout exp=step_done"); end
        repeat (60) @(posedge clk);
        #1;
        checks++; if (done_cnt - base_d != 1) begin errors++; $display("FAIL basic_done_count got=%0d exp=1", done_cnt - base_d); end
        checks++; if (start_q.size() - base_s != 8) begin errors++; $display("FAIL basic_start_count got=%0d exp=8", start_q.size() - base_s); end
        if (start_q.size() - base_s >= 8) begin
            for (int i = 0; i < 8; i++) begin
                checks++; if (start_q[base_s+i] != i) begin errors++; $display("FAIL start_order[%0d] got=%0d exp=%0d", i, start_q[base_s+i], i); end
            end
            for (int i = 0; i < 7; i++) begin
                checks++; if (start_t[base_s+i+1] - start_t[base_s+i] != 5) begin
                    errors++; $display("FAIL start_gap[%0d] got=%0d exp=5", i, start_t[base_s+i+1] - start_t[base_s+i]);
                end
            end
        end
        cpu_read(10'h202, rd);
        checks++; if (rd !== 32'h1) begin errors++; $display("FAIL basic_step_count got=%h exp=1", rd); end
        cpu_read(10'h204, rd);
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL basic_fifo_count got=%h exp=0", rd); end
        cpu_read(10'h201, rd);
        checks++; if (rd !== 32'h2) begin errors++; $display("FAIL basic_status got=%h exp=2", rd); end
        cpu_read(10'h003, rd);
        checks++; if (rd !== 32'h41200000) begin errors++; $display("FAIL input3_kept got=%h exp=41200000", rd); end
    endtask

    task automatic test_spike_pop();
        logic [31:0] rd;
        bit ok;
        int r2;
        int r5;
        int rsum;
        do_reset();
        core_spike = 8'b0010_0100;
        r2 = resolve_cnt[2];
        r5 = resolve_cnt[5];
        rsum = 0;
        for (int i = 0; i < N; i++) rsum += resolve_cnt[i];
        cpu_write(10'h200, 32'h1);
        wait_done(done_cnt, 100, ok);
        checks++; if (!ok) begin errors++; $display("FAIL spike_step_done got=timeout exp=step_done"); end
        for (int i = 0; i < N; i++) rsum -= resolve_cnt[i];
        checks++; if (resolve_cnt[2] - r2 != 1 || resolve_cnt[5] - r5 != 1 || rsum != -2) begin
            errors++; $display("FAIL resolve_pulses got r2=%0d r5=%0d total=%0d exp 1 1 2", resolve_cnt[2] - r2, resolve_cnt[5] - r5, -rsum);
        end
        cpu_read(10'h204, rd);
        checks++; if (rd !== 32'h2) begin errors++; $display("FAIL spike_fifo_count got=%h exp=2", rd); end
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_disabled got=%b exp=0", irq); end
        cpu_write(10'h200, 32'h2);
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_enabled got=%b exp=1", irq); end
        cpu_read(10'h203, rd);
        checks++; if (rd !== 32'h80000002) begin errors++; $display("FAIL pop1 got=%h exp=80000002", rd); end
        cpu_read(10'h203, rd);
        checks++; if (rd !== 32'h80000005) begin errors++; $display("FAIL pop2 got=%h exp=80000005", rd); end
        cpu_read(10'h203, rd);
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL pop_empty got=%h exp=0", rd); end
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_drained got=%b exp=0", irq); end
        cpu_read(10'h204, rd);
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL pop_empty_count got=%h exp=0", rd); end
    endtask

    task automatic test_overflow();
        logic [31:0] rd;
        bit ok;
        do_reset();
        core_spike = '1;
        for (int s = 0; s < 3; s++) begin
            cpu_write(10'h200, 32'h1);
            wait_done(done_cnt, 100, ok);
            checks++; if (!ok) begin errors++; $display("FAIL ovf_step%0d_done got=timeout exp=step_done", s); end
        end
        cpu_read(10'h204, rd);
        checks++; if (rd !== 32'd16) begin errors++; $display("FAIL ovf_fifo_count got=%0d exp=16", rd); end
        cpu_read(10'h201, rd);
        checks++; if (rd !== 32'h0C) begin errors++; $display("FAIL ovf_status got=%h exp=0c", rd); end
        cpu_write(10'h201, 32'h8);
        cpu_read(10'h201, rd);
        checks++; if (rd !== 32'h04) begin errors++; $display("FAIL ovf_cleared got=%h exp=04", rd); end
        cpu_read(10'h203, rd);
        checks++; if (rd !== 32'h80000000) begin errors++; $display("FAIL ovf_first_pop got=%h exp=80000000", rd); end
        cpu_read(10'h204, rd);
        checks++; if (rd !== 32'd15) begin errors++; $display("FAIL ovf_after_pop got=%0d exp=15", rd); end
    endtask

    task automatic test_timeout();
        logic [31:0] rd;
        bit ok;
        int base_s;
        int r4;
        do_reset();
        core_busy = 8'b0001_0000;
        core_spike = 8'b0001_1000;
        base_s = start_q.size();
        r4 = resolve_cnt[4];
        cpu_write(10'h200, 32'h1);
        wait_done(done_cnt, 400, ok);
        checks++; if (!ok) begin errors++; $display("FAIL timeout_step_done got=timeout exp=step_done"); end
        if (start_q.size() - base_s >= 6) begin
            checks++; if (start_t[base_s+5] - start_t[base_s+4] != 259) begin
                errors++; $display("FAIL timeout_gap got=%0d exp=259", start_t[base_s+5] - start_t[base_s+4]);
            end
        end else begin
            checks++; errors++; $display("FAIL timeout_starts got=%0d exp=8", start_q.size() - base_s);
        end
        checks++; if (resolve_cnt[4] != r4) begin errors++; $display("FAIL timeout_resolve4 got=%0d exp=0", resolve_cnt[4] - r4); end
        cpu_read(10'h201, rd);
        checks++; if (rd !== 32'h10) begin errors++; $display("FAIL timeout_status got=%h exp=10", rd); end
        cpu_read(10'h204, rd);
        checks++; if (rd !== 32'h1) begin errors++; $display("FAIL timeout_fifo_count got=%h exp=1", rd); end
        cpu_read(10'h203, rd);
        checks++; if (rd !== 32'h80000003) begin errors++; $display("FAIL timeout_pop got=%h exp=80000003", rd); end
        cpu_write(10'h201, 32'h10);
        cpu_read(10'h201, rd);
        checks++; if (rd !== 32'h2) begin errors++; $display("FAIL timeout_cleared got=%h exp=2", rd); end
    endtask

    task automatic test_auto_clear();
        logic [31:0] rd;
        bit ok;
        do_reset();
        cpu_write(10'h000, 32'h3F800000);
        cpu_read(10'h000, rd);
        checks++; if (rd !== 32'h3F800000) begin errors++; $display("FAIL ac_input0_rb got=%h exp=3f800000", rd); end
        cpu_write(10'h200, 32'h5);
        cpu_write(10'h001, 32'h12345678);
        cpu_read(10'h001, rd);
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL busy_write_ignored got=%h exp=0", rd); end
        wait_done(done_cnt, 100, ok);
        checks++; if (!ok) begin errors++; $display("FAIL ac_step_done got=timeout exp=step_done"); end
        cpu_read(10'h000, rd);
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL ac_input0 got=%h exp=0", rd); end
        cpu_read(10'h001, rd);
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL ac_input1 got=%h exp=0", rd); end
        checks++; if (core_input[31:0] !== 32'h0) begin errors++; $display("FAIL ac_core_input0 got=%h exp=0", core_input[31:0]); end
        cpu_read(10'h200, rd);
        checks++; if (rd !== 32'h4) begin errors++; $display("FAIL ac_ctrl got=%h exp=4", rd); end
    endtask

    task automatic test_reset_mid_step();
        logic [31:0] rd;
        int base_s;
        int base_d;
        int n;
        do_reset();
        core_busy = 8'b0000_1000;
        core_spike = 8'b0000_0010;
        base_s = start_q.size();
        cpu_write(10'h200, 32'h3);
        n = 0;
        while (start_q.size() < base_s + 4 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++; if (start_q.size() < base_s + 4) begin errors++; $display("FAIL mid_reach_idx3 got=%0d exp=4", start_q.size() - base_s); end
        repeat (4) @(posedge clk);
        #1;
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL mid_irq_before got=%b exp=1", irq); end
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        base_s = start_q.size();
        base_d = done_cnt;
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL mid_irq_after got=%b exp=0", irq); end
        cpu_read(10'h201, rd);
        checks++; if (rd !== 32'h2) begin errors++; $display("FAIL mid_status got=%h exp=2", rd); end
        cpu_read(10'h202, rd);
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL mid_step_count got=%h exp=0", rd); end
        repeat (20) @(posedge clk);
        #1;
        checks++; if (start_q.size() != base_s || done_cnt != base_d) begin
            errors++; $display("FAIL mid_no_activity got starts=%0d dones=%0d exp 0 0", start_q.size() - base_s, done_cnt - base_d);
        end
    endtask

    initial begin
        test_reset();
        test_basic_step();
        test_spike_pop();
        test_overflow();
        test_timeout();
        test_auto_clear();
        test_reset_mid_step();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end
endmodule
